// File: rtl/reaction_timer.sv
// reaction_timer -- core sequencer of the reaction-test game.
//
// A start press arms a pseudo-random delay (MIN_DELAY_MS plus the low
// RAND_BITS bits of a free-running LFSR). When the delay expires the stimulus
// LED is lit and elapsed milliseconds are counted in 4-digit BCD until the
// stop press. Early stop presses are flagged as a false start, and a count
// that would pass 9999 saturates and is flagged as an overflow.
//
// Ports:
//   iCLK      in   system clock, all logic on the rising edge
//   iRST_N    in   synchronous active-low reset
//   iSTART    in   start button (synchronised, debounced, level)
//   iSTOP     in   reaction button (synchronised, debounced, level)
//   oLED      out  stimulus LED, high only while timing
//   oDIGIT0   out  BCD ms units
//   oDIGIT1   out  BCD ms tens
//   oDIGIT2   out  BCD ms hundreds
//   oDIGIT3   out  BCD ms thousands
//   oDONE     out  valid result shown
//   oEARLY    out  stop pressed before the LED lit
//   oOVER     out  result saturated at 9999
module reaction_timer #(
   parameter int          TICK_DIV     = 50000,
   parameter int          MIN_DELAY_MS = 1000,
   parameter int          RAND_BITS    = 11,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iSTART,
   input  logic       iSTOP,
   output logic       oLED,
   output logic [3:0] oDIGIT0,
   output logic [3:0] oDIGIT1,
   output logic [3:0] oDIGIT2,
   output logic [3:0] oDIGIT3,
   output logic       oDONE,
   output logic       oEARLY,
   output logic       oOVER
);

   localparam int TICK_W  = $clog2(TICK_DIV);
   localparam int DLY_MAX = MIN_DELAY_MS + (1 << RAND_BITS) - 1;
   localparam int DLY_W   = $clog2(DLY_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_RUN,
      S_DONE,
      S_FAULT
   } state_t;

   state_t state_reg, state_next;

   logic              start_q_reg, stop_q_reg;
   logic              start_ev, stop_ev;
   logic [15:0]       lfsr_reg;
   logic              lfsr_fb;
   logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
   logic              tick;
   logic [DLY_W-1:0]  delay_reg, delay_next;
   logic [DLY_W-1:0]  delay_load;
   logic [3:0]        digit_reg  [4];
   logic [3:0]        digit_next [4];
   logic [3:0]        digit_inc  [4];
   logic [3:0]        is_nine;
   logic [3:0]        carry;
   logic              all_nines;
   logic              over_reg, over_next;
   logic              led_reg, done_reg, early_reg;
   logic              entering;

   // Press events: rising edge of the level against last cycle's copy.
   assign start_ev = iSTART & ~start_q_reg;
   assign stop_ev  = iSTOP  & ~stop_q_reg;

   // Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10).
   assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

   assign tick = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));

   // Delay is taken from the LFSR value present in the start-event cycle.
   assign delay_load = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_reg[RAND_BITS-1:0]);

   // BCD increment: each digit's carry-in is the tick gated by all lower
   // digits being 9, so every carry ripples within the same cycle.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         assign is_nine[gi] = (digit_reg[gi] == 4'd9);
         if (gi == 0) begin : g_lsd
            assign carry[gi] = tick;
         end else begin : g_upper
            assign carry[gi] = tick & (&is_nine[gi-1:0]);
         end
         assign digit_inc[gi] = !carry[gi]   ? digit_reg[gi] :
                                is_nine[gi]  ? 4'd0 :
                                               digit_reg[gi] + 4'd1;
      end
   endgenerate

   assign all_nines = &is_nine;

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (start_ev) state_next = S_WAIT;
         end
         S_WAIT: begin
            if (stop_ev)                                 state_next = S_FAULT;
            else if (tick && delay_reg <= DLY_W'(1))     state_next = S_RUN;
         end
         S_RUN: begin
            if (stop_ev)                state_next = S_DONE;
            else if (tick && all_nines) state_next = S_DONE;
         end
         S_DONE, S_FAULT: begin
            if (start_ev) state_next = S_WAIT;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign entering = (state_next != state_reg);

   // Datapath next values.
   always_comb begin
      delay_next    = delay_reg;
      over_next     = over_reg;
      digit_next    = digit_reg;
      tick_cnt_next = tick ? '0 : tick_cnt_reg + TICK_W'(1);

      // Restart the ms prescaler on every state entry.
      if (entering) tick_cnt_next = '0;

      if (state_reg == S_WAIT && tick) delay_next = delay_reg - DLY_W'(1);

      // A stop event in the tick cycle leaves RUN, so the increment is dropped.
      if (state_reg == S_RUN && state_next == S_RUN) digit_next = digit_inc;

      if (state_reg == S_RUN && !stop_ev && tick && all_nines) over_next = 1'b1;

      if (state_next == S_WAIT && entering) begin
         delay_next = delay_load;
         over_next  = 1'b0;
         for (int i = 0; i < 4; i++) digit_next[i] = 4'd0;
      end

      if (state_next == S_FAULT) begin
         for (int i = 0; i < 4; i++) digit_next[i] = 4'd0;
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_reg    <= S_IDLE;
         start_q_reg  <= 1'b0;
         stop_q_reg   <= 1'b0;
         lfsr_reg     <= LFSR_SEED;
         tick_cnt_reg <= '0;
         delay_reg    <= '0;
         over_reg     <= 1'b0;
         led_reg      <= 1'b0;
         done_reg     <= 1'b0;
         early_reg    <= 1'b0;
         for (int i = 0; i < 4; i++) digit_reg[i] <= 4'd0;
      end else begin
         state_reg    <= state_next;
         start_q_reg  <= iSTART;
         stop_q_reg   <= iSTOP;
         lfsr_reg     <= {lfsr_reg[14:0], lfsr_fb};
         tick_cnt_reg <= tick_cnt_next;
         delay_reg    <= delay_next;
         over_reg     <= over_next;
         led_reg      <= (state_next == S_RUN);
         done_reg     <= (state_next == S_DONE);
         early_reg    <= (state_next == S_FAULT);
         digit_reg    <= digit_next;
      end
   end

   assign oLED    = led_reg;
   assign oDONE   = done_reg;
   assign oEARLY  = early_reg;
   assign oOVER   = over_reg;
   assign oDIGIT0 = digit_reg[0];
   assign oDIGIT1 = digit_reg[1];
   assign oDIGIT2 = digit_reg[2];
   assign oDIGIT3 = digit_reg[3];

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Core sequencer of the reaction-test game.
- A start press arms a pseudo-random delay. The stimulus LED is then lit and elapsed milliseconds are counted in 4-digit BCD until the stop press.
- The four BCD digits feed the per-digit hex-to-7-segment decoders directly (digit 0 = least significant).
- Also flags early presses (false start) and counter overflow.

Parameters:
- TICK_DIV, 50000, iCLK cycles per 1 ms tick (50 MHz clock); must be >= 2.
- MIN_DELAY_MS, 1000, fixed part of the random delay, in ms ticks.
- RAND_BITS, 11, width of the random part of the delay; random part spans 0 .. 2^RAND_BITS-1 ticks (max 15).
- LFSR_SEED, 16'hACE1, LFSR value loaded at reset; must be non-zero.

Ports:
- iCLK  input  1  system clock; all logic on its rising edge.
- iRST_N  input  1  reset, synchronous, active-low.
- iSTART  input  1  start button, already synchronised and debounced, active-high level.
- iSTOP  input  1  reaction button, already synchronised and debounced, active-high level.
- oLED  output  1  stimulus LED; high only in RUN.
- oDIGIT0  output  4  BCD ms units.
- oDIGIT1  output  4  BCD ms tens.
- oDIGIT2  output  4  BCD ms hundreds.
- oDIGIT3  output  4  BCD ms thousands.
- oDONE  output  1  high in DONE (valid result shown).
- oEARLY  output  1  high in FAULT (stop pressed before LED).
- oOVER  output  1  high in DONE when the result saturated at 9999.

Behaviour:
- Reset (iRST_N low at a rising edge):
  - State goes to IDLE, all outputs 0, digits 0000.
  - Edge-detect registers cleared; tick and delay counters cleared; LFSR loaded with LFSR_SEED.
  - Reset has priority over everything, including mid-WAIT and mid-RUN.
- Edge detect:
  - Each button is registered once per cycle.
  - A press event is cycle N where input=1 and the registered copy=0.
  - A held level produces exactly one event.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every non-reset cycle, in all states.
- Tick generator:
  - Counts 0..TICK_DIV-1. tick=1 in the cycle the count equals TICK_DIV-1, then it wraps to 0.
  - Cleared on every state entry, so the first tick occurs TICK_DIV cycles after entry.
- States:
  - IDLE: outputs low, digits 0000. Start event -> WAIT.
  - WAIT:
    - Entry loads delay = MIN_DELAY_MS + LFSR[RAND_BITS-1:0], using the LFSR value in the start-event cycle. Digits clear to 0000.
    - Each tick decrements delay; tick with delay==1 -> RUN.
    - Stop event -> FAULT.
    - Start events ignored.
  - RUN:
    - oLED=1 from the first cycle after the transition.
    - Each tick increments the digits as a BCD counter, with carries 9->0 into the next digit in the same cycle.
    - Stop event -> DONE. If a stop event and a tick coincide, stop wins and the increment is dropped.
    - A tick at 9999 does not wrap: digits hold 9999, state -> DONE, oOVER=1.
    - Start events ignored.
  - DONE:
    - oLED=0, oDONE=1, digits frozen at the final value.
    - Start event -> WAIT, which clears digits and oOVER. Stop events ignored.
  - FAULT:
    - oEARLY=1, digits 0000, oLED=0.
    - Start event -> WAIT, which clears oEARLY. Stop events ignored.
- Timing:
  - All outputs are registered.
  - State changes become visible on outputs 1 cycle after the triggering event cycle.
  - Digits never hold a non-BCD value (a-f).
- Simultaneous start and stop events: handled by the current state's rules above. In IDLE, start wins.

Test Plan:
- Sim parameters for all scenarios: TICK_DIV=4, MIN_DELAY_MS=3, RAND_BITS=2.
- Reset and idle: hold iRST_N=0 for 3 cycles, then release with no presses -> all outputs 0, digits 0000, LED never lit for 100 cycles.
- Normal trial: start pulse, bench records LFSR[1:0]=r at the event.
  - Required: oLED rises exactly 4*(3+r)+1 cycles after the event.
  - Stop held high 4*37 cycles after oLED rises -> digits read 0,0,3,7 (oDIGIT3..0), oDONE=1, oLED=0.
- False start: start, then stop during WAIT -> oEARLY=1, oLED stays 0, digits 0000. A second start clears oEARLY and re-enters WAIT.
- Carry and overflow: run with no stop.
  - Check digits pass 0009->0010, 0099->0100 and 0999->1000, each in a single cycle.
  - At 9999 + one tick -> digits stay 9999, oOVER=1, oDONE=1.
- Coincidence and hold: stop event in the same cycle as a tick -> count not incremented. Start held high through a full trial -> exactly one trial launched.
- Mid-run reset: pull iRST_N low for one cycle during RUN -> next cycle oLED=0, digits 0000, state IDLE; a subsequent start works normally.
